// File: rtl/interrupt_controller.sv
// Bus-mapped four-source interrupt controller: edge-captured pending bits, enable mask,
// fixed-priority arbitration (source 0 highest) and CPU request/acknowledge handshake.
module interrupt_controller #(
  parameter logic [7:0]  BaseAddr      = 8'hE0,
  parameter int unsigned NumSources    = 4,
  parameter logic [3:0]  InitialEnable = 4'b1111
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] SRC_IRQ_RAISE,
  output logic [3:0] SRC_IRQ_ACK,
  output logic       CPU_IRQ_RAISE,
  output logic [1:0] CPU_IRQ_VECTOR,
  input  logic       CPU_IRQ_ACK
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;

  state_t     state, state_next;
  logic [1:0] vector, vector_next;
  logic [3:0] raise_prev, pending, enable, edges, clr, active;
  logic [7:0] off, rd_data;
  logic       rd_valid, cpu_raise_r;
  logic [3:0] src_ack_r;

  assign off    = BUS_ADDR - BaseAddr;
  assign edges  = SRC_IRQ_RAISE & ~raise_prev;
  assign active = pending & enable;

  // Clearing sources: bus write-1-to-clear and the acknowledged source; new edges override both.
  always_comb begin
    clr = '0;
    if (BUS_WE && off == 8'd3) clr = BUS_DATA[3:0];
    if (state == ACK) clr[vector] = 1'b1;
  end

  always_comb begin
    state_next  = state;
    vector_next = vector;
    case (state)
      IDLE: begin
        if (|active) begin
          state_next = REQ;
          for (int unsigned i = NumSources; i > 0; i--) begin
            if (active[i-1]) vector_next = 2'(i - 1);
          end
        end
      end
      REQ:     if (CPU_IRQ_ACK) state_next = ACK;
      ACK:     state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      vector      <= '0;
      pending     <= '0;
      enable      <= InitialEnable;
      raise_prev  <= '0;
      cpu_raise_r <= 1'b0;
      src_ack_r   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      state       <= state_next;
      vector      <= vector_next;
      pending     <= (pending & ~clr) | edges;
      raise_prev  <= SRC_IRQ_RAISE;
      if (BUS_WE && off == 8'd1) enable <= BUS_DATA[3:0];
      cpu_raise_r <= (state_next == REQ);
      src_ack_r   <= (state_next == ACK) ? (4'b0001 << vector_next) : '0;
      rd_valid    <= (off < 8'd4) && !BUS_WE;
      case (off[1:0])
        2'd0:    rd_data <= {4'h0, pending};
        2'd1:    rd_data <= {4'h0, enable};
        2'd2:    rd_data <= {cpu_raise_r, 5'b0, vector};
        default: rd_data <= '0;
      endcase
    end
  end

  assign SRC_IRQ_ACK    = src_ack_r;
  assign CPU_IRQ_RAISE  = cpu_raise_r;
  assign CPU_IRQ_VECTOR = vector;
  assign BUS_DATA       = (rd_valid && !BUS_WE) ? rd_data : 'z;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Bus-mapped interrupt controller. It sits between the peripheral interrupt sources (timer, mouse, IR, etc.) and the microprocessor's single interrupt input. It latches RAISE requests from up to four sources, masks them, and arbitrates by fixed priority. It presents one request plus a vector to the CPU and routes the CPU's acknowledge back to the originating source as its ACK.

Parameters:
BaseAddr, 8'hE0, bus base address of the register block
NumSources, 4, number of interrupt sources (fixed at 4; vector is 2 bits)
InitialEnable, 4'b1111, enable mask loaded at reset

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
BUS_DATA  inout  8  shared data bus, tristated when not driving
BUS_ADDR  input  8  bus address
BUS_WE  input  1  bus write enable
SRC_IRQ_RAISE  input  4  level request from each source; held high until acked
SRC_IRQ_ACK  output  4  one-cycle acknowledge pulse to each source
CPU_IRQ_RAISE  output  1  request to processor
CPU_IRQ_VECTOR  output  2  index of the source being presented
CPU_IRQ_ACK  input  1  processor acknowledge (one-cycle pulse)

Behaviour:
- Reset:
  - Synchronous, active-high on RESET; clock CLK.
  - Pending=0, Enable=InitialEnable, FSM=IDLE, RaisePrev=0.
  - SRC_IRQ_ACK=0, CPU_IRQ_RAISE=0, CPU_IRQ_VECTOR=0, BUS_DATA=Z.
  - Reset mid-request abandons the request; no ACK is issued.
- Edge capture:
  - RaisePrev registers SRC_IRQ_RAISE.
  - Pending[i] sets when RAISE[i]=1 and RaisePrev[i]=0.
  - Set takes priority over any clear in the same cycle.
- Registers (write when BUS_ADDR matches and BUS_WE=1):
  - Base+0: Pending (read-only).
  - Base+1: Enable[3:0] (R/W; BUS_DATA[3:0]).
  - Base+2: status {Busy, 5'b0, Vector[1:0]} (read-only).
  - Base+3: write-1-to-clear Pending[3:0] (reads as 0).
- Bus read:
  - The address match is registered. BUS_DATA is driven the cycle after BUS_ADDR matches a readable offset (Base+0..+3), otherwise Z.
  - The controller never drives the bus during BUS_WE=1.
- FSM:
  - IDLE: if (Pending & Enable) != 0, select the lowest set index (source 0 = highest priority) and latch it into Vector. Go to REQ next cycle. Latency from the RAISE rising edge to CPU_IRQ_RAISE=1 is 2 cycles when IDLE.
  - REQ: CPU_IRQ_RAISE=1, CPU_IRQ_VECTOR=Vector, Busy=1. The request is not retracted if Enable or Pending for Vector changes meanwhile. Stay until CPU_IRQ_ACK=1, then go to ACK.
  - ACK (1 cycle): SRC_IRQ_ACK[Vector]=1, other bits 0. Clear Pending[Vector] unless a new edge arrives the same cycle. CPU_IRQ_RAISE=0. Go to GAP.
  - GAP (1 cycle): CPU_IRQ_RAISE=0, then go to IDLE. This guarantees at least 2 low cycles between consecutive CPU requests.
  - CPU_IRQ_ACK outside REQ is ignored.
- Simultaneous events:
  - Multiple pending sources are served one at a time in priority order.
  - A source re-raised while being served is captured as new pending only if RAISE returns low and high again.
  - Disabled sources stay pending and are served once enabled.
- Outputs are registered. CPU_IRQ_VECTOR holds its last value outside REQ.

Test Plan:
1. RESET 3 cycles, then read Base+1 → 8'h0F on BUS_DATA one cycle after address; CPU_IRQ_RAISE=0; SRC_IRQ_ACK=0.
2. Raise source 2; 2 cycles later CPU_IRQ_RAISE=1 and VECTOR=2. Pulse CPU_IRQ_ACK → next cycle SRC_IRQ_ACK=4'b0100 for exactly 1 cycle; Pending reads 0; CPU_IRQ_RAISE low for ≥2 cycles.
3. Raise sources 1 and 3 in the same cycle → served as VECTOR=1 then VECTOR=3. Each receives exactly one ACK pulse, and CPU_IRQ_RAISE drops between them.
4. Write 8'h0E to Base+1, then raise source 0 → no CPU_IRQ_RAISE, Pending=8'h01. Write 8'h0F → request appears 1 cycle later with VECTOR=0.
5. Raise source 1, write 8'h02 to Base+3 before enable → Pending=0, no request. Then set and clear in the same cycle → Pending[1]=1 (set wins).
6. Assert RESET while in REQ → next cycle CPU_IRQ_RAISE=0, Pending=0, no SRC_IRQ_ACK pulse.
